ram_fifo_ctrl: RTL and testbench

- FIFO controller that sits directly upstream of the 16x16 dual-port RAM and drives both of its ports.
- Port 0 is used for writes only; port 1 is used for reads only.
- Keeps write/read pointers and an occupancy count, and presents push/pop handshakes to the producer and consumer.
- Captures read data from the RAM's registered, output-enabled port 1 and returns it with a valid pulse.

---
 rtl/ram_fifo_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller in front of a 16x16 dual-port RAM. Port 0 is driven as a
//   write-only port, port 1 as a read-only port with a registered,
//   output-enabled data path. Keeps write/read pointers and an occupancy count,
//   and offers push/pop handshakes to producer and consumer.
//
// Optional feature (compile-time macro FIFO_ERR_EN):
//   When defined, adds sticky error flags ovf_err (push while full) and
//   udf_err (pop while empty and idle). When undefined, the ports do not exist
//   and illegal requests are silently ignored.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   push, push_data          producer request and word
//   push_ready               push accepted this cycle (FIFO not full)
//   pop, pop_ready           consumer request / accepted this cycle
//   rd_data, rd_valid        captured word and its one-cycle valid pulse
//   count                    occupied entries 0..DEPTH
//   ram_*0                   RAM port 0 (write only)
//   ram_*1, ram_rdata1       RAM port 1 (read only) and its data bus
//   ovf_err, udf_err         sticky error flags (FIFO_ERR_EN only)
//
// Read FSM:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RD_IDLE  | port 1 idle; a pop is accepted when the FIFO is not empty
//   RD_ISSUE | cs1 high with address; RAM latches the word at end of cycle
//   RD_DRIVE | cs1 + op_en1 high; word captured, rd_ptr/count advance
//
// DEPTH must equal 2**ADDR_W so the pointers wrap naturally.

module ram_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic              pop_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_ad0,
  output logic              ram_cs0,
  output logic              ram_w_en0,
  output logic              ram_op_en0,
  output logic [DATA_W-1:0] ram_wdata0,
  output logic [ADDR_W-1:0] ram_ad1,
  output logic              ram_cs1,
  output logic              ram_w_en1,
  output logic              ram_op_en1,
  input  logic [DATA_W-1:0] ram_rdata1
`ifdef FIFO_ERR_EN
  ,
  output logic              ovf_err,
  output logic              udf_err
`endif
);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_acc;
  logic              pop_acc;
  logic              capture;

  assign push_ready = (count != FULL_CNT);
  assign pop_ready  = (rd_state == RD_IDLE) && (count != '0);

  // Gated with reset_n so the port-0 strobes drop the instant reset asserts,
  // even if the producer keeps push high.
  assign push_acc = push && push_ready && reset_n;
  assign pop_acc  = pop && pop_ready;
  assign capture  = (rd_state == RD_DRIVE);

  // Port 0: write only, strobes straight from the accepted push.
  assign ram_cs0    = push_acc;
  assign ram_w_en0  = push_acc;
  assign ram_ad0    = wr_ptr;
  assign ram_wdata0 = push_data;
  assign ram_op_en0 = 1'b0;

  // Port 1: read only; address follows rd_ptr, which only moves at capture.
  assign ram_ad1    = rd_ptr;
  assign ram_w_en1  = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (push_acc) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
    end
  end

  // The word being read stays counted until capture, which keeps the writer
  // from reusing its slot while ISSUE/DRIVE are still in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({push_acc, capture})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Read FSM with registered port-1 strobes and capture outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state   <= RD_IDLE;
      rd_ptr     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      ram_cs1    <= 1'b0;
      ram_op_en1 <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (pop_acc) begin
            rd_state   <= RD_ISSUE;
            ram_cs1    <= 1'b1;
            ram_op_en1 <= 1'b0;
          end
        end
        RD_ISSUE: begin
          rd_state   <= RD_DRIVE;
          ram_cs1    <= 1'b1;
          ram_op_en1 <= 1'b1;
        end
        RD_DRIVE: begin
          rd_data    <= ram_rdata1;
          rd_valid   <= 1'b1;
          rd_ptr     <= rd_ptr + ADDR_W'(1);
          rd_state   <= RD_IDLE;
          ram_cs1    <= 1'b0;
          ram_op_en1 <= 1'b0;
        end
        default: begin
          rd_state   <= RD_IDLE;
          ram_cs1    <= 1'b0;
          ram_op_en1 <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (push && !push_ready) begin
        ovf_err <= 1'b1;
      end
      if (pop && (count == '0) && (rd_state == RD_IDLE)) begin
        udf_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: behavioural RAM on both ports, a queue-based
// reference FIFO, directed scenarios and a randomized push/pop phase.

module tb_ram_fifo_ctrl;

  logic        clk;
  logic        reset_n;
  logic        push;
  logic [15:0] push_data;
  logic        push_ready;
  logic        pop;
  logic        pop_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic [3:0]  ram_ad0;
  logic        ram_cs0;
  logic        ram_w_en0;
  logic        ram_op_en0;
  logic [15:0] ram_wdata0;
  logic [3:0]  ram_ad1;
  logic        ram_cs1;
  logic        ram_w_en1;
  logic        ram_op_en1;
  logic [15:0] ram_rdata1;
`ifdef FIFO_ERR_EN
  logic        ovf_err;
  logic        udf_err;
`endif

  ram_fifo_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (pop),
    .pop_ready  (pop_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .ram_ad0    (ram_ad0),
    .ram_cs0    (ram_cs0),
    .ram_w_en0  (ram_w_en0),
    .ram_op_en0 (ram_op_en0),
    .ram_wdata0 (ram_wdata0),
    .ram_ad1    (ram_ad1),
    .ram_cs1    (ram_cs1),
    .ram_w_en1  (ram_w_en1),
    .ram_op_en1 (ram_op_en1),
    .ram_rdata1 (ram_rdata1)
`ifdef FIFO_ERR_EN
    ,
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x16 dual-port RAM: port 0 writes, port 1 latches on cs and drives on op_en.
  logic [15:0] mem [16];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs0 && ram_w_en0) mem[ram_ad0] <= ram_wdata0;
    if (ram_cs1 && !ram_w_en1) ram_q <= mem[ram_ad1];
  end
  assign ram_rdata1 = ram_op_en1 ? ram_q : 16'h0000;

  // Reference model: queue of stored words plus a countdown of read cycles.
  logic [15:0] q[$];
  int          m_busy;   // 2 = issue cycle, 1 = drive cycle, 0 = idle
  int          m_wr;
  int          m_rd;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ovf;
  logic        m_udf;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_busy  = 0;
    m_wr    = 0;
    m_rd    = 0;
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check combinational and
  // registered outputs, advance the model across the rising edge.
  task automatic step(input logic p, input logic [15:0] pd, input logic r);
    logic exp_pr, exp_rr, acc_p, acc_r;
    int   sz;
    push = p; push_data = pd; pop = r;
    #1;
    sz     = q.size();
    exp_pr = (sz != 16);
    exp_rr = (m_busy == 0) && (sz != 0);
    acc_p  = p && exp_pr;
    acc_r  = r && exp_rr;
    check("push_ready", push_ready, exp_pr);
    check("pop_ready", pop_ready, exp_rr);
    check("count", count, sz);
    check("cs0", ram_cs0, acc_p);
    check("w_en0", ram_w_en0, acc_p);
    check("op_en0", ram_op_en0, 0);
    check("w_en1", ram_w_en1, 0);
    if (acc_p) begin
      check("ad0", ram_ad0, m_wr);
      check("wdata0", ram_wdata0, pd);
    end
    check("cs1", ram_cs1, m_busy != 0);
    check("op_en1", ram_op_en1, m_busy == 1);
    if (m_busy != 0) check("ad1", ram_ad1, m_rd);
    if (acc_p && m_busy != 0) check("slot_sep", ram_ad0 != ram_ad1, 1);
    check("rd_valid", rd_valid, m_valid);
    check("rd_data", rd_data, m_data);
`ifdef FIFO_ERR_EN
    check("ovf_err", ovf_err, m_ovf);
    check("udf_err", udf_err, m_udf);
    if (p && !exp_pr) m_ovf = 1'b1;
    if (r && sz == 0 && m_busy == 0) m_udf = 1'b1;
`endif
    m_valid = 1'b0;
    if (m_busy == 1) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
      m_rd    = (m_rd + 1) % 16;
    end
    if (m_busy > 0) m_busy--;
    if (acc_p) begin
      q.push_back(pd);
      m_wr = (m_wr + 1) % 16;
    end
    if (acc_r) m_busy = 2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; push_data = 16'h0000;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_cs1", ram_cs1, 0);
    check("rst_op_en1", ram_op_en1, 0);
    reset_n = 1'b1;
    model_clear();
  endtask

  // Hold pop until the model is empty and idle, then one more cycle so the
  // final rd_valid pulse is checked.
  task automatic drain();
    for (int i = 0; i < 200 && (q.size() != 0 || m_busy != 0); i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("drain_count", count, 0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // First push after reset lands at address 0.
    step(1'b1, 16'hA001, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    drain();

    // Three words in, three out in order; pop on empty is ignored.
    step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    drain();

    // Fill to 16, refused 17th push, drain in order.
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    drain();

    // Pointer wrap from a clean start: second batch hits 12..15 then 0..3.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0);
    drain();
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0800 + 16'(i), 1'b0);
    drain();

    // Push on the same edge as a capture at count=5.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 5);
    drain();

    // Reset during the drive cycle of a read.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h7700 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("pre_rst_in_drive", ram_op_en1, 1);
    push = 1'b1; push_data = 16'h9999;
    reset_n = 1'b0;
    #1;
    check("arst_cs0", ram_cs0, 0);
    check("arst_w_en0", ram_w_en0, 0);
    check("arst_cs1", ram_cs1, 0);
    check("arst_op_en1", ram_op_en1, 0);
    check("arst_count", count, 0);
    check("arst_rd_valid", rd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("arst_no_valid", rd_valid, 0);
    push = 1'b0;
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h4242, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
